// File: rtl/ofs_fim_pcie_ats_tx_arb.sv
// ofs_fim_pcie_ats_tx_arb
// Packet-aware 2:1 scheduler that merges the AFU TX TLP stream with locally
// generated ATS invalidation-completion TLPs onto one TX AXI-S port.
// Arbitration happens only at packet boundaries. Completions get priority,
// but only for CPL_BURST packets in a row while the AFU is waiting. The
// output stage is registered. Completion latency and count telemetry are
// exported to the ATS CSR block.
module ofs_fim_pcie_ats_tx_arb #(
  parameter int TDATA_WIDTH = 512,
  parameter int TUSER_WIDTH = 10,
  parameter int CPL_BURST   = 4,
  parameter int WAIT_CNT_W  = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       afu_tvalid,
  output logic                       afu_tready,
  input  logic                       afu_tlast,
  input  logic [TDATA_WIDTH-1:0]     afu_tdata,
  input  logic [TDATA_WIDTH/8-1:0]   afu_tkeep,
  input  logic [TUSER_WIDTH-1:0]     afu_tuser,
  input  logic                       cpl_tvalid,
  output logic                       cpl_tready,
  input  logic                       cpl_tlast,
  input  logic [TDATA_WIDTH-1:0]     cpl_tdata,
  input  logic [TDATA_WIDTH/8-1:0]   cpl_tkeep,
  input  logic [TUSER_WIDTH-1:0]     cpl_tuser,
  output logic                       o_tvalid,
  input  logic                       o_tready,
  output logic                       o_tlast,
  output logic [TDATA_WIDTH-1:0]     o_tdata,
  output logic [TDATA_WIDTH/8-1:0]   o_tkeep,
  output logic [TUSER_WIDTH-1:0]     o_tuser,
  output logic [31:0]                cpl_sent_cnt,
  output logic [WAIT_CNT_W-1:0]      cpl_wait_max
);

  // Burst limit expressed at the width of the run counter (limit <= 255).
  localparam logic [7:0] BURST_MAX = 8'(CPL_BURST);

  typedef enum logic [1:0] {
    ARB      = 2'd0,
    LOCK_AFU = 2'd1,
    LOCK_CPL = 2'd2
  } state_t;

  state_t                   state_r;
  state_t                   state_s;
  logic [7:0]               cpl_run_r;
  logic [WAIT_CNT_W-1:0]    cpl_wait_r;
  logic [WAIT_CNT_W-1:0]    cpl_wait_max_r;
  logic [31:0]              cpl_sent_cnt_r;
  logic                     o_tvalid_r;
  logic                     o_tlast_r;
  logic [TDATA_WIDTH-1:0]   o_tdata_r;
  logic [TDATA_WIDTH/8-1:0] o_tkeep_r;
  logic [TUSER_WIDTH-1:0]   o_tuser_r;
  logic                     adv_s;
  logic                     grant_cpl_s;
  logic                     grant_afu_s;
  logic                     cpl_acc_s;
  logic                     afu_acc_s;

  // The output register may load when it is empty or being drained.
  assign adv_s      = o_tready || !o_tvalid_r;
  assign cpl_tready = adv_s && grant_cpl_s;
  assign afu_tready = adv_s && grant_afu_s;
  assign cpl_acc_s  = cpl_tvalid && cpl_tready;
  assign afu_acc_s  = afu_tvalid && afu_tready;

  assign o_tvalid     = o_tvalid_r;
  assign o_tlast      = o_tlast_r;
  assign o_tdata      = o_tdata_r;
  assign o_tkeep      = o_tkeep_r;
  assign o_tuser      = o_tuser_r;
  assign cpl_sent_cnt = cpl_sent_cnt_r;
  assign cpl_wait_max = cpl_wait_max_r;

  // Select the one source allowed to move a beat this cycle; a locked packet
  // keeps its source even when only the other input is valid.
  always_comb begin
    grant_cpl_s = 1'b0;
    grant_afu_s = 1'b0;
    case (state_r)
      ARB: begin
        if (cpl_tvalid && ((cpl_run_r < BURST_MAX) || !afu_tvalid)) begin
          grant_cpl_s = 1'b1;
        end else if (afu_tvalid) begin
          grant_afu_s = 1'b1;
        end else begin
          grant_cpl_s = 1'b0;
          grant_afu_s = 1'b0;
        end
      end
      LOCK_AFU: grant_afu_s = 1'b1;
      LOCK_CPL: grant_cpl_s = 1'b1;
      default: begin
        grant_cpl_s = 1'b0;
        grant_afu_s = 1'b0;
      end
    endcase
  end

  // Track packet boundaries: lock on a non-final first beat, unlock on tlast.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ARB: begin
        if (cpl_acc_s && !cpl_tlast) begin
          state_s = LOCK_CPL;
        end else if (afu_acc_s && !afu_tlast) begin
          state_s = LOCK_AFU;
        end else begin
          state_s = ARB;
        end
      end
      LOCK_AFU: begin
        if (afu_acc_s && afu_tlast) begin
          state_s = ARB;
        end else begin
          state_s = LOCK_AFU;
        end
      end
      LOCK_CPL: begin
        if (cpl_acc_s && cpl_tlast) begin
          state_s = ARB;
        end else begin
          state_s = LOCK_CPL;
        end
      end
      default: state_s = ARB;
    endcase
  end

  // Packet-boundary state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ARB;
    end else begin
      state_r <= state_s;
    end
  end

  // Count completion packets granted back-to-back while the AFU is waiting;
  // an idle AFU or an AFU packet start restarts the count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cpl_run_r <= 8'd0;
    end else if (adv_s && (state_r == ARB)) begin
      if (!afu_tvalid) begin
        cpl_run_r <= 8'd0;
      end else if (cpl_acc_s) begin
        if (cpl_run_r < BURST_MAX) begin
          cpl_run_r <= cpl_run_r + 8'd1;
        end else begin
          cpl_run_r <= cpl_run_r;
        end
      end else if (afu_acc_s) begin
        cpl_run_r <= 8'd0;
      end else begin
        cpl_run_r <= cpl_run_r;
      end
    end else begin
      cpl_run_r <= cpl_run_r;
    end
  end

  // Registered output stage; fields hold while a beat is stalled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      o_tvalid_r <= 1'b0;
    end else if (adv_s) begin
      o_tvalid_r <= cpl_acc_s || afu_acc_s;
      if (cpl_acc_s) begin
        o_tlast_r <= cpl_tlast;
        o_tdata_r <= cpl_tdata;
        o_tkeep_r <= cpl_tkeep;
        o_tuser_r <= cpl_tuser;
      end else if (afu_acc_s) begin
        o_tlast_r <= afu_tlast;
        o_tdata_r <= afu_tdata;
        o_tkeep_r <= afu_tkeep;
        o_tuser_r <= afu_tuser;
      end else begin
        o_tlast_r <= o_tlast_r;
        o_tdata_r <= o_tdata_r;
        o_tkeep_r <= o_tkeep_r;
        o_tuser_r <= o_tuser_r;
      end
    end else begin
      o_tvalid_r <= o_tvalid_r;
    end
  end

  // Completion wait telemetry: current head-beat wait and its worst case,
  // sampled at the packet's first beat before the wait counter clears.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cpl_wait_r     <= {WAIT_CNT_W{1'b0}};
      cpl_wait_max_r <= {WAIT_CNT_W{1'b0}};
    end else begin
      if (cpl_acc_s) begin
        cpl_wait_r <= {WAIT_CNT_W{1'b0}};
      end else if (cpl_tvalid && (cpl_wait_r != {WAIT_CNT_W{1'b1}})) begin
        cpl_wait_r <= cpl_wait_r + {{(WAIT_CNT_W-1){1'b0}}, 1'b1};
      end else begin
        cpl_wait_r <= cpl_wait_r;
      end
      if (cpl_acc_s && (state_r == ARB) && (cpl_wait_r > cpl_wait_max_r)) begin
        cpl_wait_max_r <= cpl_wait_r;
      end else begin
        cpl_wait_max_r <= cpl_wait_max_r;
      end
    end
  end

  // Count forwarded completion packets on their final beat; wraps.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cpl_sent_cnt_r <= 32'd0;
    end else if (cpl_acc_s && cpl_tlast) begin
      cpl_sent_cnt_r <= cpl_sent_cnt_r + 32'd1;
    end else begin
      cpl_sent_cnt_r <= cpl_sent_cnt_r;
    end
  end

endmodule

// File: tb/tb_ofs_fim_pcie_ats_tx_arb.sv
// Self-checking bench for ofs_fim_pcie_ats_tx_arb: a vector table for the
// grant rules, directed sequences for multi-cycle corners, and randomized
// traffic checked against a per-source packet scoreboard.
module tb_ofs_fim_pcie_ats_tx_arb;

  localparam int DW = 64;
  localparam int KW = DW / 8;
  localparam int UW = 10;
  localparam int WW = 16;
  localparam int NPKT = 40;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          afu_tvalid = 1'b0, afu_tready, afu_tlast = 1'b0;
  logic [DW-1:0] afu_tdata = '0;
  logic [KW-1:0] afu_tkeep = '0;
  logic [UW-1:0] afu_tuser = '0;
  logic          cpl_tvalid = 1'b0, cpl_tready, cpl_tlast = 1'b0;
  logic [DW-1:0] cpl_tdata = '0;
  logic [KW-1:0] cpl_tkeep = '0;
  logic [UW-1:0] cpl_tuser = '0;
  logic          o_tvalid, o_tready = 1'b1, o_tlast;
  logic [DW-1:0] o_tdata;
  logic [KW-1:0] o_tkeep;
  logic [UW-1:0] o_tuser;
  logic [31:0]   cpl_sent_cnt;
  logic [WW-1:0] cpl_wait_max;

  int compared = 0;
  int mismatched = 0;

  ofs_fim_pcie_ats_tx_arb #(
    .TDATA_WIDTH(DW), .TUSER_WIDTH(UW), .CPL_BURST(4), .WAIT_CNT_W(WW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .afu_tvalid(afu_tvalid), .afu_tready(afu_tready), .afu_tlast(afu_tlast),
    .afu_tdata(afu_tdata), .afu_tkeep(afu_tkeep), .afu_tuser(afu_tuser),
    .cpl_tvalid(cpl_tvalid), .cpl_tready(cpl_tready), .cpl_tlast(cpl_tlast),
    .cpl_tdata(cpl_tdata), .cpl_tkeep(cpl_tkeep), .cpl_tuser(cpl_tuser),
    .o_tvalid(o_tvalid), .o_tready(o_tready), .o_tlast(o_tlast),
    .o_tdata(o_tdata), .o_tkeep(o_tkeep), .o_tuser(o_tuser),
    .cpl_sent_cnt(cpl_sent_cnt), .cpl_wait_max(cpl_wait_max)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       av;
    logic       cv;
    logic       ordy;
    logic       exp_ardy;
    logic       exp_crdy;
    logic       exp_ov;
    logic [15:0] exp_tag;
  } vec_t;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic [UW-1:0] u;
    logic          l;
  } beat_t;

  vec_t  vt[11];
  beat_t src_a[$], src_c[$], exp_a[$], exp_c[$];
  logic  pk[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic idle();
    afu_tvalid = 1'b0;
    cpl_tvalid = 1'b0;
    afu_tlast  = 1'b0;
    cpl_tlast  = 1'b0;
    o_tready   = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    beat_t x, prev_o;
    logic  acc_a, acc_c, prev_stall, out_mid, out_src, src, take_a, a_beat;
    int    len, n_cpl_out, cyc;

    // Grant-rule vectors; every beat is single-beat so the state stays ARB.
    vt[0]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000};
    vt[1]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'hA001};
    vt[2]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 16'hC002};
    vt[3]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 16'hC003};
    vt[4]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 16'hC004};
    vt[5]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 16'hC005};
    vt[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 16'hC006};
    vt[7]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 16'hA007};
    vt[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'hA007};
    vt[9]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 16'hC009};
    vt[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000};

    // Reset state.
    do_reset();
    #1;
    chk("rst_o_tvalid", 64'(o_tvalid), 64'd0);
    chk("rst_sent_cnt", 64'(cpl_sent_cnt), 64'd0);
    chk("rst_wait_max", 64'(cpl_wait_max), 64'd0);

    // Vector table.
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      afu_tvalid = vt[i].av;
      cpl_tvalid = vt[i].cv;
      afu_tlast  = 1'b1;
      cpl_tlast  = 1'b1;
      afu_tdata  = 64'(16'hA000 | 16'(i));
      cpl_tdata  = 64'(16'hC000 | 16'(i));
      o_tready   = vt[i].ordy;
      #1;
      chk($sformatf("vec%0d_afu_tready", i), 64'(afu_tready), 64'(vt[i].exp_ardy));
      chk($sformatf("vec%0d_cpl_tready", i), 64'(cpl_tready), 64'(vt[i].exp_crdy));
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_o_tvalid", i), 64'(o_tvalid), 64'(vt[i].exp_ov));
      if (vt[i].exp_ov) begin
        chk($sformatf("vec%0d_o_tdata", i), 64'(o_tdata[15:0]), 64'(vt[i].exp_tag));
        chk($sformatf("vec%0d_o_tlast", i), 64'(o_tlast), 64'd1);
      end
    end

    // Single 3-beat AFU packet.
    do_reset();
    for (int b = 0; b < 3; b++) begin
      @(negedge clk);
      afu_tvalid = 1'b1;
      afu_tlast  = (b == 2);
      afu_tdata  = 64'(100 + b);
      #1;
      chk("a3_afu_tready", 64'(afu_tready), 64'd1);
      @(posedge clk);
      #1;
      chk("a3_o_tvalid", 64'(o_tvalid), 64'd1);
      chk("a3_o_tdata", o_tdata, 64'(100 + b));
      chk("a3_o_tlast", 64'(o_tlast), 64'(b == 2));
    end
    @(negedge clk);
    idle();
    @(posedge clk);
    #1;
    chk("a3_o_tvalid_end", 64'(o_tvalid), 64'd0);
    chk("a3_sent_cnt", 64'(cpl_sent_cnt), 64'd0);

    // Completion arrives mid AFU packet: waits for the AFU tlast.
    do_reset();
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      afu_tvalid = 1'b1;
      afu_tlast  = (b == 3);
      afu_tdata  = 64'(200 + b);
      if (b == 2) begin
        cpl_tvalid = 1'b1;
        cpl_tlast  = 1'b1;
        cpl_tdata  = 64'h8000_0000_0000_0055;
      end
      #1;
      if (b >= 2) chk("lock_cpl_tready", 64'(cpl_tready), 64'd0);
      @(posedge clk);
      #1;
      chk("lock_o_tdata", o_tdata, 64'(200 + b));
    end
    @(negedge clk);
    afu_tvalid = 1'b0;
    #1;
    chk("lock_cpl_granted", 64'(cpl_tready), 64'd1);
    @(posedge clk);
    #1;
    chk("lock_cpl_b2b_valid", 64'(o_tvalid), 64'd1);
    chk("lock_cpl_b2b_data", o_tdata, 64'h8000_0000_0000_0055);
    @(negedge clk);
    idle();
    @(posedge clk);
    #1;
    chk("lock_wait_max", 64'(cpl_wait_max), 64'd2);
    chk("lock_sent_cnt", 64'(cpl_sent_cnt), 64'd1);

    // Reset mid AFU packet.
    for (int b = 0; b < 2; b++) begin
      @(negedge clk);
      afu_tvalid = 1'b1;
      afu_tlast  = 1'b0;
      afu_tdata  = 64'(300 + b);
    end
    @(negedge clk);
    rst_n = 1'b0;
    idle();
    @(posedge clk);
    #1;
    chk("mrst_o_tvalid", 64'(o_tvalid), 64'd0);
    chk("mrst_sent_cnt", 64'(cpl_sent_cnt), 64'd0);
    chk("mrst_wait_max", 64'(cpl_wait_max), 64'd0);
    @(negedge clk);
    rst_n      = 1'b1;
    afu_tvalid = 1'b1;
    afu_tlast  = 1'b0;
    cpl_tvalid = 1'b1;
    cpl_tlast  = 1'b1;
    cpl_tdata  = 64'h8000_0000_0000_0077;
    #1;
    chk("mrst_cpl_tready", 64'(cpl_tready), 64'd1);
    chk("mrst_afu_tready", 64'(afu_tready), 64'd0);
    @(posedge clk);
    #1;
    chk("mrst_o_tdata", o_tdata, 64'h8000_0000_0000_0077);
    @(negedge clk);
    idle();

    // Completion counter wrap.
    force dut.cpl_sent_cnt_r = 32'hFFFF_FFFF;
    @(posedge clk);
    @(negedge clk);
    release dut.cpl_sent_cnt_r;
    cpl_tvalid = 1'b1;
    cpl_tlast  = 1'b1;
    cpl_tdata  = 64'h8000_0000_0000_0099;
    @(posedge clk);
    @(negedge clk);
    idle();
    #1;
    chk("wrap_sent_cnt", 64'(cpl_sent_cnt), 64'd0);

    // Both sources always valid: expect C,C,C,C,A repeating.
    do_reset();
    a_beat     = 1'b0;
    afu_tvalid = 1'b1;
    cpl_tvalid = 1'b1;
    cpl_tlast  = 1'b1;
    cpl_tdata  = 64'h8000_0000_0000_0000;
    afu_tdata  = 64'h0;
    pk.delete();
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      afu_tlast = a_beat;
      #1;
      if (o_tvalid && o_tlast) pk.push_back(o_tdata[63]);
      take_a = afu_tvalid && afu_tready;
      @(posedge clk);
      if (take_a) a_beat = ~a_beat;
    end
    @(negedge clk);
    idle();
    chk("burst_pkt_count_ok", 64'(pk.size() >= 15), 64'd1);
    for (int i = 0; i < 15 && i < pk.size(); i++) begin
      chk($sformatf("burst_order%0d", i), 64'(pk[i]), 64'((i % 5) != 4));
    end

    // Randomized mixed traffic with o_tready toggling every cycle.
    do_reset();
    src_a.delete(); src_c.delete(); exp_a.delete(); exp_c.delete();
    for (int p = 0; p < NPKT; p++) begin
      len = $urandom_range(1, 3);
      for (int b = 0; b < len; b++) begin
        x.d = {1'b0, 15'(p), 16'(b), 32'($urandom)};
        x.k = KW'($urandom);
        x.u = UW'($urandom);
        x.l = (b == len - 1);
        src_a.push_back(x);
      end
      len = $urandom_range(1, 3);
      for (int b = 0; b < len; b++) begin
        x.d = {1'b1, 15'(p), 16'(b), 32'($urandom)};
        x.k = KW'($urandom);
        x.u = UW'($urandom);
        x.l = (b == len - 1);
        src_c.push_back(x);
      end
    end
    acc_a = 1'b0; acc_c = 1'b0; prev_stall = 1'b0; out_mid = 1'b0; out_src = 1'b0;
    n_cpl_out = 0;
    prev_o = '0;
    cyc = 0;
    while (cyc < 4000 && (cyc < 50 || src_a.size() > 0 || src_c.size() > 0 ||
                          exp_a.size() > 0 || exp_c.size() > 0)) begin
      @(negedge clk);
      if (acc_a) begin exp_a.push_back(src_a.pop_front()); afu_tvalid = 1'b0; end
      if (acc_c) begin exp_c.push_back(src_c.pop_front()); cpl_tvalid = 1'b0; end
      o_tready = 1'(cyc % 2);
      if (!afu_tvalid && src_a.size() > 0 && $urandom_range(0, 2) != 0) begin
        afu_tvalid = 1'b1;
        {afu_tdata, afu_tkeep, afu_tuser, afu_tlast} = src_a[0];
      end
      if (!cpl_tvalid && src_c.size() > 0 && $urandom_range(0, 2) != 0) begin
        cpl_tvalid = 1'b1;
        {cpl_tdata, cpl_tkeep, cpl_tuser, cpl_tlast} = src_c[0];
      end
      #1;
      if (afu_tready && cpl_tready) chk("rnd_ready_exclusive", 64'd1, 64'd0);
      if (prev_stall) begin
        chk("rnd_stall_valid", 64'(o_tvalid), 64'd1);
        if ({o_tdata, o_tkeep, o_tuser, o_tlast} !== prev_o)
          chk("rnd_stall_stable", 64'(o_tdata), 64'(prev_o.d));
      end
      if (o_tvalid && o_tready) begin
        src = o_tdata[63];
        if (out_mid) chk("rnd_no_interleave", 64'(src), 64'(out_src));
        out_mid = !o_tlast;
        out_src = src;
        if (src && o_tlast) n_cpl_out++;
        if (src ? (exp_c.size() == 0) : (exp_a.size() == 0)) begin
          chk("rnd_unexpected_beat", o_tdata, 64'd0);
        end else begin
          x = src ? exp_c.pop_front() : exp_a.pop_front();
          chk("rnd_beat_data", o_tdata, x.d);
          chk("rnd_beat_side", 64'({o_tkeep, o_tuser, o_tlast}), 64'({x.k, x.u, x.l}));
        end
      end
      prev_stall = o_tvalid && !o_tready;
      prev_o     = {o_tdata, o_tkeep, o_tuser, o_tlast};
      acc_a      = afu_tvalid && afu_tready;
      acc_c      = cpl_tvalid && cpl_tready;
      @(posedge clk);
      cyc++;
    end
    @(negedge clk);
    idle();
    chk("rnd_drained", 64'(src_a.size() + src_c.size() + exp_a.size() + exp_c.size()), 64'd0);
    chk("rnd_cpl_pkts_out", 64'(n_cpl_out), 64'(NPKT));
    chk("rnd_sent_cnt", 64'(cpl_sent_cnt), 64'(NPKT));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/ofs_fim_pcie_ats_tx_arb.md
Name: ofs_fim_pcie_ats_tx_arb

Overview:
- Packet-aware 2:1 scheduler that merges the AFU TX TLP stream with locally generated ATS invalidation-completion TLPs onto the single FIM-to-host TX AXI-S port.
- Arbitration decisions are made only at output packet boundaries. Completions get priority, bounded by a burst limit so the AFU is never starved.
- Provides a registered output stage plus completion-latency and count telemetry for the ATS CSR block.

Parameters:
TDATA_WIDTH, 512, AXI-S data width in bits; tkeep width is TDATA_WIDTH/8.
TUSER_WIDTH, 10, tuser_vendor width in bits.
CPL_BURST, 4, maximum consecutive completion packets granted while AFU is waiting; range 1..255.
WAIT_CNT_W, 16, width of completion wait counters.

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
afu_tvalid  in  1  AFU TX valid
afu_tready  out  1  AFU TX ready
afu_tlast  in  1  AFU end of packet
afu_tdata  in  TDATA_WIDTH  AFU data
afu_tkeep  in  TDATA_WIDTH/8  AFU byte enables
afu_tuser  in  TUSER_WIDTH  AFU tuser_vendor
cpl_tvalid  in  1  ATS completion valid
cpl_tready  out  1  ATS completion ready
cpl_tlast  in  1  completion end of packet
cpl_tdata  in  TDATA_WIDTH  completion data
cpl_tkeep  in  TDATA_WIDTH/8  completion byte enables
cpl_tuser  in  TUSER_WIDTH  completion tuser_vendor
o_tvalid  out  1  merged TX valid
o_tready  in  1  merged TX ready
o_tlast  out  1  merged end of packet
o_tdata  out  TDATA_WIDTH  merged data
o_tkeep  out  TDATA_WIDTH/8  merged byte enables
o_tuser  out  TUSER_WIDTH  merged tuser_vendor
cpl_sent_cnt  out  32  completion packets forwarded; wraps
cpl_wait_max  out  WAIT_CNT_W  worst-case cycles a completion head beat waited; saturating

Behaviour:
- Clock clk; reset rst_n is synchronous and active-low.
- Reset values: o_tvalid=0, state=ARB, cpl_run=0, cpl_wait=0, cpl_wait_max=0, cpl_sent_cnt=0. o_tdata, o_tkeep, o_tuser and o_tlast are don't-care while o_tvalid=0.
- adv = o_tready || !o_tvalid. The output register loads only when adv=1.
- Latency: an accepted input beat appears on o_* on the next cycle. With o_tready held high, throughput is 1 beat per cycle.
- States:
  - ARB: at a packet boundary.
  - LOCK_AFU: mid AFU packet.
  - LOCK_CPL: mid completion packet.
- ARB grant rules, evaluated combinationally each cycle:
  - grant cpl if cpl_tvalid && (cpl_run < CPL_BURST || !afu_tvalid);
  - else grant afu if afu_tvalid;
  - else no grant.
- Ready rules:
  - cpl_tready = adv && (LOCK_CPL || (ARB && cpl granted)).
  - afu_tready = adv && (LOCK_AFU || (ARB && afu granted)).
  - Both readies are never asserted in the same cycle.
- Transitions on an accepted beat:
  - ARB to LOCK_x if the beat has tlast=0; stays in ARB if tlast=1.
  - LOCK_x to ARB on the accepted beat with tlast=1.
  - In a LOCK state the other input is never granted, even if only the other input is valid.
- cpl_run:
  - Increments (saturating at CPL_BURST) on every accepted cpl beat taken from ARB state, i.e. once per packet.
  - Clears to 0 on every AFU packet start accepted in ARB.
  - Clears to 0 in any ARB cycle with !afu_tvalid.
- The loaded output beat carries the accepted beat's tlast, tdata, tkeep and tuser unmodified. o_tvalid=1 if a beat was accepted, else 0 when adv=1.
- o_* fields are held stable while o_tvalid && !o_tready (AXI-S compliance).
- cpl_wait:
  - Counts cycles in which cpl_tvalid && !cpl_tready, saturating at all-ones.
  - Clears to 0 on an accepted cpl beat.
  - On each accepted cpl beat taken in ARB, cpl_wait_max = max(cpl_wait_max, cpl_wait), comparing the pre-clear value.
- cpl_sent_cnt increments by 1 on each accepted cpl beat with tlast=1 and wraps from 2^32-1 to 0.
- Simultaneous tvalid in ARB with cpl_run < CPL_BURST: completion wins.
- Reset mid-packet: state returns to ARB and o_tvalid drops on the next edge. No partial-packet recovery; upstream sources are reset by the same rst_n.
- Backpressure while a beat is held: no input is accepted and no state or counter changes except cpl_wait.

Test Plan:
- Single 3-beat AFU packet, o_tready=1, no cpl -> 3 beats on o_* starting 1 cycle after the first accept, in order with tlast on beat 3; cpl_sent_cnt=0.
- cpl_tvalid raised during beat 2 of a 4-beat AFU packet -> cpl_tready stays 0 until the AFU tlast is accepted; completion follows the AFU tlast beat back-to-back; cpl_wait_max=2.
- Both sources continuously valid, CPL_BURST=4, single-beat cpl, 2-beat AFU packets -> output packet order is C,C,C,C,A,C,C,C,C,A,...
- o_tready toggled 0/1 every cycle during mixed traffic -> no beat dropped or duplicated; o_* stable while stalled; cpl_sent_cnt equals the number of cpl packets sent.
- rst_n asserted for 1 cycle mid AFU packet -> o_tvalid=0 and all counters 0 the following cycle; a new cpl packet is granted from ARB.
- cpl_sent_cnt preset by forcing to 0xFFFFFFFF, then 1 cpl packet sent -> counter reads 0.
